// File: rtl/fifo_wr_pkg.sv
// Shared types and helpers for the FIFO write-side packer.
package fifo_wr_pkg;

  // Default width of one FIFO entry; producer words are twice this.
  localparam int FIFO_WIDTH_DEF = 16;

  // Packer states. WR_CSUM is only reachable when the checksum build is on.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_LO   = 2'd1,
    WR_HI   = 2'd2,
    WR_CSUM = 2'd3
  } wr_state_e;

  // The FIFO takes a write only when we request it, it has room, and no read
  // is in flight in the same cycle. A read collision silently drops the
  // write, so it must be treated exactly like full.
  function automatic logic wr_accept(input logic wen, input logic full,
                                     input logic ren);
    return wen & ~full & ~ren;
  endfunction

endpackage

// File: rtl/fifo_wr_csum.sv
// Per-packet running checksum: sum of data halves modulo 2^W.
module fifo_wr_csum #(
  parameter int W = 16
) (
  input  logic         clk_a,
  input  logic         rst,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  // Clear wins over add; the packer never requests both in one cycle.
  always_ff @(posedge clk_a) begin
    if (rst || clr) sum <= '0;
    else if (add_en) sum <= sum + din;
  end

endmodule

// File: rtl/fifo_wr_packer.sv
// Write-side packer: splits 2*FIFO_WIDTH words into low/high FIFO writes.
// Optional per-packet checksum half enabled by defining FIFO_WR_CSUM_EN.
module fifo_wr_packer
  import fifo_wr_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int PKT_CNT_W  = 8
) (
  input  logic                    clk_a,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [2*FIFO_WIDTH-1:0] s_data,
  input  logic                    s_last,
  input  logic                    fifo_full,
  input  logic                    fifo_ren,
  output logic                    fifo_wen,
  output logic [FIFO_WIDTH-1:0]   fifo_din,
  output logic                    fifo_enable,
  output logic [15:0]             half_count,
  output logic [PKT_CNT_W-1:0]    pkt_count,
  output logic                    busy
);

  wr_state_e               state, nxt;
  logic [2*FIFO_WIDTH-1:0] hold_data;
  logic                    hold_last;
  logic                    accept;
  logic                    data_acc;
  logic                    pkt_done;

  assign accept   = wr_accept(fifo_wen, fifo_full, fifo_ren);
  assign data_acc = accept && (state == WR_LO || state == WR_HI);
  assign busy     = (state != IDLE);

`ifdef FIFO_WR_CSUM_EN
  logic [FIFO_WIDTH-1:0] csum;
  logic                  csum_clr;

  assign csum_clr = accept && (state == WR_CSUM);
  assign pkt_done = csum_clr;

  fifo_wr_csum #(.W(FIFO_WIDTH)) u_csum (
    .clk_a  (clk_a),
    .rst    (rst),
    .clr    (csum_clr),
    .add_en (data_acc),
    .din    (fifo_din),
    .sum    (csum)
  );
`else
  assign pkt_done = accept && (state == WR_HI) && hold_last;
`endif

  // State register.
  always_ff @(posedge clk_a) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and Moore outputs; fifo_din is zero whenever not writing.
  always_comb begin
    nxt      = state;
    s_ready  = 1'b0;
    fifo_wen = 1'b0;
    fifo_din = '0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) nxt = WR_LO;
      end
      WR_LO: begin
        fifo_wen = 1'b1;
        fifo_din = hold_data[FIFO_WIDTH-1:0];
        if (accept) nxt = WR_HI;
      end
      WR_HI: begin
        fifo_wen = 1'b1;
        fifo_din = hold_data[2*FIFO_WIDTH-1:FIFO_WIDTH];
`ifdef FIFO_WR_CSUM_EN
        if (accept) nxt = hold_last ? WR_CSUM : IDLE;
`else
        if (accept) nxt = IDLE;
`endif
      end
      WR_CSUM: begin
`ifdef FIFO_WR_CSUM_EN
        fifo_wen = 1'b1;
        fifo_din = csum;
        if (accept) nxt = IDLE;
`else
        nxt = IDLE;
`endif
      end
      default: nxt = IDLE;
    endcase
  end

  // Capture the producer word on handshake; held until both halves land.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      hold_data <= '0;
      hold_last <= 1'b0;
    end else if (state == IDLE && s_valid) begin
      hold_data <= s_data;
      hold_last <= s_last;
    end
  end

  // Accepted-half and completed-packet counters, both free-running wraps.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      half_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (data_acc) half_count <= half_count + 16'd1;
      if (pkt_done) pkt_count  <= pkt_count + PKT_CNT_W'(1);
    end
  end

  // FIFO global enable rises the first cycle out of reset.
  always_ff @(posedge clk_a) begin
    if (rst) fifo_enable <= 1'b0;
    else     fifo_enable <= 1'b1;
  end

endmodule
